// File: rtl/siso_frame_ctrl_pkg.sv
// Shared types and default sizing for the serial frame controller.
// Holds the FSM state encoding used by the controller.
package siso_frame_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DIV_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/siso_frame_ctrl_if.sv
// Producer-side handshake and serial output bundle for siso_frame_ctrl.
// master = word producer / serial observer, slave = controller.
interface siso_frame_ctrl_if #(
    parameter int DATA_W = siso_frame_pkg::DEF_DATA_W,
    parameter int DIV_W  = siso_frame_pkg::DEF_DIV_W
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [DIV_W-1:0]  bit_div;
    logic              sout;
    logic              sout_en;
    logic              busy;
    logic              done;

    modport master (
        output in_valid, in_data, bit_div,
        input  in_ready, sout, sout_en, busy, done
    );

    modport slave (
        input  in_valid, in_data, bit_div,
        output in_ready, sout, sout_en, busy, done
    );
endinterface

// File: rtl/siso_frame_ctrl_shift_reg.sv
// Parallel-load, MSB-first shift register (zero fill).
// Latency: load/shift visible on msb the cycle after. Backpressure: none, load wins over shift.
module siso_shift_reg #(
    parameter int DATA_W = siso_frame_pkg::DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] din,
    output logic              msb
);
    logic [DATA_W-1:0] shreg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= din;
        end else if (shift) begin
            shreg <= {shreg[DATA_W-2:0], 1'b0};
        end
    end

    assign msb = shreg[DATA_W-1];
endmodule

// File: rtl/siso_frame_ctrl.sv
// Serialises accepted parallel words MSB-first, each bit held bit_div+1 cycles.
// Latency: first bit the cycle after accept; DATA_W*(bit_div+1) shift cycles + 1 DONE cycle.
// Backpressure: in_ready only in IDLE, decoded from state (no in_valid->in_ready path).
module siso_frame_ctrl
    import siso_frame_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DIV_W  = DEF_DIV_W
) (
    input  logic               clk,
    input  logic               rst,
    siso_frame_ctrl_if.slave   io
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DIV_W-1:0]   div_cnt;
    logic [DIV_W-1:0]   period;
    logic               accept;
    logic               bit_end;
    logic               shift_en;
    logic               msb;

    logic               in_ready_c;
    logic               sout_c;
    logic               sout_en_c;
    logic               busy_c;
    logic               done_c;

    assign bit_end  = (div_cnt == period);
    assign accept   = (state == IDLE) && io.in_valid;
    assign shift_en = (state == SHIFT) && bit_end;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready_c = 1'b0;
        sout_c     = 1'b0;
        sout_en_c  = 1'b0;
        busy_c     = 1'b0;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                in_ready_c = 1'b1;
                if (io.in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                busy_c    = 1'b1;
                sout_en_c = 1'b1;
                sout_c    = msb;
                if (bit_end && (bit_cnt == LAST_BIT)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy_c    = 1'b1;
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // period is latched at accept so bit_div may change freely mid-frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            div_cnt <= '0;
            period  <= '0;
        end else if (accept) begin
            bit_cnt <= '0;
            div_cnt <= '0;
            period  <= io.bit_div;
        end else if (state == SHIFT) begin
            if (bit_end) begin
                div_cnt <= '0;
                bit_cnt <= bit_cnt + 1'b1;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    siso_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift_reg (
        .clk   (clk),
        .rst   (rst),
        .load  (accept),
        .shift (shift_en),
        .din   (io.in_data),
        .msb   (msb)
    );

    assign io.in_ready = in_ready_c;
    assign io.sout     = sout_c;
    assign io.sout_en  = sout_en_c;
    assign io.busy     = busy_c;
    assign io.done     = done_c;
endmodule

// File: tb/tb_siso_frame_ctrl.sv
// Scoreboard bench for siso_frame_ctrl: stimulus queues expected bits/done/ready per cycle,
// a negedge monitor pops and compares whenever the DUT presents sout_en, done or a ready point.
module tb_siso_frame_ctrl;
    localparam int DW = 8;
    localparam int VW = 4;

    typedef struct {
        int   cyc;
        logic b;
    } exp_bit_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   pcyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    exp_bit_t bitq[$];
    int       doneq[$];
    int       rdyq[$];

    siso_frame_ctrl_if #(.DATA_W(DW), .DIV_W(VW)) io ();

    siso_frame_ctrl #(.DATA_W(DW), .DIV_W(VW)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io)
    );

    always #5 clk = ~clk;
    always @(posedge clk) pcyc <= pcyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, pcyc);
        end
    endtask

    task automatic fail(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: unexpected event at cycle %0d", name, pcyc);
    endtask

    // accept observed at negedge with pcyc=p; bit k of the frame shows at pcyc=p+k
    task automatic expect_frame(input int p, input logic [DW-1:0] d, input logic [VW-1:0] dv);
        int n = 0;
        for (int i = DW - 1; i >= 0; i--) begin
            for (int r = 0; r <= int'(dv); r++) begin
                n++;
                bitq.push_back('{cyc: p + n, b: d[i]});
            end
        end
        doneq.push_back(p + n + 1);
        rdyq.push_back(p + n + 2);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (io.sout_en) begin
                if (bitq.size() == 0) begin
                    fail("extra_bit");
                end else begin
                    exp_bit_t e;
                    e = bitq.pop_front();
                    chk("bit_cycle", pcyc, e.cyc);
                    chk("sout", io.sout, e.b);
                    chk("busy_in_shift", io.busy, 1'b1);
                end
            end
            if (io.done) begin
                if (doneq.size() == 0) begin
                    fail("extra_done");
                end else begin
                    chk("done_cycle", pcyc, doneq.pop_front());
                    chk("sout_en_in_done", io.sout_en, 1'b0);
                    chk("busy_in_done", io.busy, 1'b1);
                end
            end
            if (rdyq.size() != 0 && pcyc >= rdyq[0]) begin
                chk("ready_cycle", pcyc, rdyq.pop_front());
                chk("in_ready_after", io.in_ready, 1'b1);
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [VW-1:0] dv, input bit hold);
        int w = 0;
        @(negedge clk);
        io.in_valid = 1'b1;
        io.in_data  = d;
        io.bit_div  = dv;
        while (!io.in_ready && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (!io.in_ready) begin
            fail("accept_timeout");
            io.in_valid = 1'b0;
            return;
        end
        expect_frame(pcyc, d, dv);
        if (!hold) begin
            @(negedge clk);
            io.in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int w = 0;
        while ((bitq.size() != 0 || doneq.size() != 0 || rdyq.size() != 0) && w < 600) begin
            @(negedge clk);
            w++;
        end
        chk("pending_bits", bitq.size(), 0);
        chk("pending_done", doneq.size(), 0);
        chk("idle_ready", io.in_ready, 1'b1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, io.in_ready, 1'b1);
        chk({tag, "_sout"},     io.sout,     1'b0);
        chk({tag, "_sout_en"},  io.sout_en,  1'b0);
        chk({tag, "_busy"},     io.busy,     1'b0);
        chk({tag, "_done"},     io.done,     1'b0);
    endtask

    initial begin
        io.in_valid = 1'b0;
        io.in_data  = '0;
        io.bit_div  = '0;

        repeat (2) @(negedge clk);
        chk_reset_outputs("rst");
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk_reset_outputs("post_rst");

        send(8'hA5, 4'd0, 1'b0);
        drain();

        send(8'h81, 4'd2, 1'b0);
        drain();

        send(8'hF0, 4'd0, 1'b1);
        send(8'h0F, 4'd0, 1'b0);
        drain();

        // stimulus changes while busy must not disturb the captured frame
        send(8'hC3, 4'd1, 1'b0);
        repeat (3) @(negedge clk);
        io.in_data  = 8'hFF;
        io.bit_div  = 4'd7;
        io.in_valid = 1'b1;
        repeat (4) @(negedge clk);
        io.in_valid = 1'b0;
        drain();

        send(8'h3C, 4'hF, 1'b0);
        drain();

        send(8'hAA, 4'd0, 1'b0);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        #1 chk_reset_outputs("mid_rst");
        bitq.delete();
        doneq.delete();
        rdyq.delete();
        repeat (2) @(negedge clk);
        chk_reset_outputs("mid_rst_hold");
        #1 rst = 1'b1;

        send(8'h55, 4'd0, 1'b0);
        drain();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
